// File: rtl/signed_threshold_debounce_pkg.sv
// Shared types and helpers for the signed threshold debounce block.
package signed_threshold_debounce_pkg;

    // Debounce FSM state encoding, fixed so it can be probed from outside.
    typedef enum logic [1:0] {
        LOW     = 2'd0,
        RISING  = 2'd1,
        HIGH    = 2'd2,
        FALLING = 2'd3
    } state_e;

    // Width of a counter that must hold values 0..debounce.
    function automatic int cntWidth(input int debounce);
        return (debounce < 1) ? 1 : $clog2(debounce + 1);
    endfunction

endpackage

// File: rtl/signed_threshold_debounce_ge.sv
// Combinational two's-complement compare: O = (I0 >= I1).
module signed_ge #(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    output logic             O
);

    logic [WIDTH-1:0] diff;
    logic             ovf;

    // The subtraction can overflow when the operand signs differ; in that case
    // the difference sign is inverted, so the true sign is msb XOR overflow.
    always_comb begin
        diff = I0 - I1;
        ovf  = (I0[WIDTH-1] ^ I1[WIDTH-1]) & (I0[WIDTH-1] ^ diff[WIDTH-1]);
        O    = ~(diff[WIDTH-1] ^ ovf);
    end

endmodule

// File: rtl/signed_threshold_debounce.sv
// Registered signed threshold detector with a counting debounce FSM and
// one-cycle RISE/FALL pulses on each change of the debounced level.
module signed_threshold_debounce
    import signed_threshold_debounce_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int DEBOUNCE = 3
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic [WIDTH-1:0] I,
    input  logic [WIDTH-1:0] THRESH,
    input  logic             VALID,
    output logic             O,
    output logic             RISE,
    output logic             FALL
);

    localparam int            CW    = cntWidth(DEBOUNCE);
    localparam logic [CW-1:0] DEB_C = CW'(DEBOUNCE);

    logic          geComb;
    logic          ge_q;
    logic          v_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cntInc;
    logic          o_q, o_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    signed_ge #(.WIDTH(WIDTH)) uGe (
        .I0(I),
        .I1(THRESH),
        .O (geComb)
    );

    // Stage 1: register the compare result and its qualifier every cycle.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            ge_q <= 1'b0;
            v_q  <= 1'b0;
        end else begin
            ge_q <= geComb;
            v_q  <= VALID;
        end
    end

    // Stage 2 next-state: only qualified samples advance or break a run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cntInc  = cnt_q + CW'(1);
        if (v_q) begin
            case (state_q)
                LOW: begin
                    if (ge_q) begin
                        if (DEBOUNCE == 1) begin
                            state_d = HIGH;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = RISING;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                RISING: begin
                    if (ge_q) begin
                        if (cntInc == DEB_C) begin
                            state_d = HIGH;
                            rise_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end
                end
                HIGH: begin
                    if (!ge_q) begin
                        if (DEBOUNCE == 1) begin
                            state_d = LOW;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = FALLING;
                            cnt_d   = CW'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
                FALLING: begin
                    if (!ge_q) begin
                        if (cntInc == DEB_C) begin
                            state_d = LOW;
                            fall_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cntInc;
                        end
                    end else begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            endcase
        end
        o_d = (state_d == HIGH) || (state_d == FALLING);
    end

    // Stage 2 register: state, counter and all outputs update together.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            state_q <= LOW;
            cnt_q   <= '0;
            o_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign O    = o_q;
    assign RISE = rise_q;
    assign FALL = fall_q;

endmodule

// File: tb/tb_signed_threshold_debounce.sv
// Directed and random bench for signed_threshold_debounce with a scoreboard
// model running DEBOUNCE=3 and DEBOUNCE=1 instances side by side.
module tb_signed_threshold_debounce;
    import signed_threshold_debounce_pkg::*;

    typedef struct packed {
        logic o3, r3, f3, o1, r1, f1;
    } expT;

    logic       clock = 1'b0;
    logic       asyncReset = 1'b1;
    logic [1:0] sampleIn = 2'b00;
    logic [1:0] threshIn = 2'b00;
    logic       validIn = 1'b0;
    logic       out3, rise3, fall3;
    logic       out1, rise1, fall1;

    int   checks = 0;
    int   failures = 0;
    expT  expQ[$];
    logic geQ[$];
    logic lvl3, lvl1;
    int   run3, run1;

    signed_threshold_debounce #(.WIDTH(2), .DEBOUNCE(3)) dut3 (
        .CLK(clock), .ASYNCRESET(asyncReset), .I(sampleIn), .THRESH(threshIn),
        .VALID(validIn), .O(out3), .RISE(rise3), .FALL(fall3)
    );

    signed_threshold_debounce #(.WIDTH(2), .DEBOUNCE(1)) dut1 (
        .CLK(clock), .ASYNCRESET(asyncReset), .I(sampleIn), .THRESH(threshIn),
        .VALID(validIn), .O(out1), .RISE(rise1), .FALL(fall1)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference debounce: counts consecutive valid samples that disagree with the level.
    task automatic modelStep(input logic ge, input int deb, inout logic lvl, inout int run,
                             output logic rp, output logic fp);
        rp = 1'b0;
        fp = 1'b0;
        if (ge != lvl) begin
            run++;
            if (run >= deb) begin
                lvl = ge;
                rp  = ge;
                fp  = ~ge;
                run = 0;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic compareScoreboard(input string tag);
        expT e;
        logic g;
        if (expQ.size() == 0) begin
            checkOutput({tag, ".queueEmpty"}, 8'd0, 8'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, ".d3"}, {5'd0, out3, rise3, fall3}, {5'd0, e.o3, e.r3, e.f3});
            checkOutput({tag, ".d1"}, {5'd0, out1, rise1, fall1}, {5'd0, e.o1, e.r1, e.f1});
        end
        if (geQ.size() > 1) begin
            g = geQ.pop_front();
            checkOutput({tag, ".ge3"}, {7'd0, dut3.ge_q}, {7'd0, g});
            checkOutput({tag, ".ge1"}, {7'd0, dut1.ge_q}, {7'd0, g});
        end
    endtask

    task automatic applyStimulus(input logic [1:0] iVal, input logic [1:0] tVal, input logic vld,
                                 input string tag);
        logic ge;
        expT  e;
        @(posedge clock);
        #1;
        sampleIn = iVal;
        threshIn = tVal;
        validIn  = vld;
        ge = ($signed(iVal) >= $signed(tVal));
        e = '0;
        if (vld) begin
            modelStep(ge, 3, lvl3, run3, e.r3, e.f3);
            modelStep(ge, 1, lvl1, run1, e.r1, e.f1);
        end
        e.o3 = lvl3;
        e.o1 = lvl1;
        expQ.push_back(e);
        geQ.push_back(ge);
        @(negedge clock);
        compareScoreboard(tag);
    endtask

    // Reset asserted mid-cycle must clear everything immediately.
    task automatic applyReset();
        @(negedge clock);
        asyncReset = 1'b1;
        validIn    = 1'b0;
        #1;
        checkOutput("reset.out3", {5'd0, out3, rise3, fall3}, 8'd0);
        checkOutput("reset.out1", {5'd0, out1, rise1, fall1}, 8'd0);
        checkOutput("reset.state", 8'(dut3.state_q), 8'(LOW));
        checkOutput("reset.cnt", 8'(dut3.cnt_q), 8'd0);
        checkOutput("reset.ge", {6'd0, dut3.ge_q, dut3.v_q}, 8'd0);
        @(posedge clock);
        #2;
        asyncReset = 1'b0;
        expQ.delete();
        geQ.delete();
        expQ.push_back('0);
        expQ.push_back('0);
        lvl3 = 1'b0;
        lvl1 = 1'b0;
        run3 = 0;
        run1 = 0;
    endtask

    initial begin
        $display("[TB] start");
        applyReset();

        // Test 1: build up RISING cnt=2, then reset mid-run.
        applyStimulus(2'b01, 2'b00, 1'b1, "t1.s0");
        applyStimulus(2'b01, 2'b00, 1'b1, "t1.s1");
        applyStimulus(2'b01, 2'b00, 1'b0, "t1.idle0");
        applyStimulus(2'b01, 2'b00, 1'b0, "t1.idle1");
        checkOutput("t1.preState", 8'(dut3.state_q), 8'(RISING));
        checkOutput("t1.preCnt", 8'(dut3.cnt_q), 8'd2);
        applyReset();
        applyStimulus(2'b01, 2'b00, 1'b1, "t1.fresh0");
        applyStimulus(2'b01, 2'b00, 1'b1, "t1.fresh1");
        for (int k = 0; k < 3; k++) applyStimulus(2'b01, 2'b00, 1'b0, "t1.gap");
        applyStimulus(2'b01, 2'b00, 1'b1, "t1.fresh2");
        for (int k = 0; k < 3; k++) applyStimulus(2'b00, 2'b00, 1'b0, "t1.flush");

        // Test 6: from HIGH, low twice, high once, low three times.
        applyStimulus(2'b11, 2'b00, 1'b1, "t6.lo0");
        applyStimulus(2'b11, 2'b00, 1'b1, "t6.lo1");
        applyStimulus(2'b01, 2'b00, 1'b1, "t6.hi");
        applyStimulus(2'b11, 2'b00, 1'b1, "t6.lo2");
        applyStimulus(2'b11, 2'b00, 1'b1, "t6.lo3");
        applyStimulus(2'b11, 2'b00, 1'b1, "t6.lo4");
        for (int k = 0; k < 3; k++) applyStimulus(2'b00, 2'b00, 1'b0, "t6.flush");

        // Test 3: two high samples then one low, no rise.
        applyStimulus(2'b01, 2'b00, 1'b1, "t3.s0");
        applyStimulus(2'b01, 2'b00, 1'b1, "t3.s1");
        applyStimulus(2'b10, 2'b00, 1'b1, "t3.s2");
        for (int k = 0; k < 3; k++) applyStimulus(2'b00, 2'b00, 1'b0, "t3.flush");
        checkOutput("t3.state", 8'(dut3.state_q), 8'(LOW));

        // Test 2: negative threshold, zero input, three valid samples.
        applyStimulus(2'b00, 2'b11, 1'b1, "t2.s0");
        applyStimulus(2'b00, 2'b11, 1'b1, "t2.s1");
        applyStimulus(2'b00, 2'b11, 1'b1, "t2.s2");
        applyStimulus(2'b00, 2'b11, 1'b0, "t2.c3");
        applyStimulus(2'b00, 2'b11, 1'b0, "t2.c4");
        applyStimulus(2'b00, 2'b11, 1'b0, "t2.c5");

        // Return to LOW before the gap test.
        for (int k = 0; k < 3; k++) applyStimulus(2'b10, 2'b00, 1'b1, "t4.pre");
        for (int k = 0; k < 2; k++) applyStimulus(2'b10, 2'b00, 1'b0, "t4.preflush");

        // Test 4: valid samples separated by invalid cycles.
        applyStimulus(2'b01, 2'b00, 1'b1, "t4.c0");
        applyStimulus(2'b01, 2'b00, 1'b0, "t4.c1");
        applyStimulus(2'b01, 2'b00, 1'b1, "t4.c2");
        applyStimulus(2'b01, 2'b00, 1'b0, "t4.c3");
        applyStimulus(2'b01, 2'b00, 1'b1, "t4.c4");
        for (int k = 0; k < 3; k++) applyStimulus(2'b01, 2'b00, 1'b0, "t4.flush");

        // Test 5: signed corners, including the overflowing subtraction.
        applyStimulus(2'b10, 2'b01, 1'b1, "t5.m2ge1");
        applyStimulus(2'b01, 2'b01, 1'b1, "t5.1ge1");
        applyStimulus(2'b01, 2'b10, 1'b1, "t5.1gem2");
        applyStimulus(2'b10, 2'b10, 1'b1, "t5.m2gem2");
        applyStimulus(2'b00, 2'b00, 1'b0, "t5.flush");

        // Random sweep exercising DEBOUNCE=1 toggling alongside DEBOUNCE=3.
        for (int k = 0; k < 40; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 3) != 0), "sweep");
        end
        for (int k = 0; k < 3; k++) applyStimulus(2'b00, 2'b00, 1'b0, "final.flush");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
